// File: rtl/jpeg_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_buf_arbiter
// Purpose  : Shares the single-port JPEG output buffer RAM between the encoder
//            writer and the SPI readout reader. The writer has priority, a
//            bounded burst guard keeps the reader from starving, and reads
//            return through a fixed-latency pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_buf_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int MAX_WR_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_WR_BURST);

    logic              w_wr_grant;
    logic              w_rd_grant;
    logic              w_burst_full;
    logic [3:0]        r_wr_burst;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_issued;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    always_comb begin
        w_burst_full = (r_wr_burst >= c_MAX_BURST);
        w_wr_grant   = !reset && wr_req && (!rd_req || !w_burst_full);
        w_rd_grant   = !reset && rd_req && !w_wr_grant;
    end

    assign wr_ack = w_wr_grant;
    assign rd_ack = w_rd_grant;

    // Counts only writer grants that made a waiting reader wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_burst <= 4'd0;
        end else if (w_rd_grant || !rd_req) begin
            r_wr_burst <= 4'd0;
        end else if (w_wr_grant && !w_burst_full) begin
            r_wr_burst <= r_wr_burst + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_wr_grant || w_rd_grant;
            r_mem_we <= w_wr_grant;
            if (w_wr_grant) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end else if (w_rd_grant) begin
                r_mem_addr  <= rd_addr;
            end
        end
    end

    // Stage 1 tracks a read the RAM sampled; stage 2 captures its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_issued <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_issued <= r_mem_en && !r_mem_we;
            r_rd_valid  <= r_rd_issued;
            if (r_rd_issued) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_buf_arbiter
// Purpose  : Directed and randomized checks of jpeg_buf_arbiter against a
//            transaction-level reference model with its own buffer image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_buf_arbiter;

    localparam int c_MAX   = 4;
    localparam int c_DEPTH = 131072;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    jpeg_buf_arbiter #(
        .ADDR_W       (17),
        .DATA_W       (8),
        .MAX_WR_BURST (c_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM the arbiter drives.
    logic [7:0] ram [0:c_DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_exp_t;

    // Reference model state
    logic [7:0]  mdl_mem [0:c_DEPTH-1];
    rd_exp_t     rd_q [$];
    int          burst;
    logic        e_en, e_we, e_rv;
    logic [16:0] e_addr;
    logic [7:0]  e_wdata, e_rd_data;
    int          cyc;
    int          rd_wait;
    int          we_cnt, rv_cnt;
    logic        last_wr_ack, last_rd_ack;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic i_wr, input logic [16:0] i_wa, input logic [7:0] i_wd,
                        input logic i_rd, input logic [16:0] i_ra, input logic i_rst);
        logic g_wr, g_rd;
        @(negedge clk);
        e_rv = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e_rv      = 1'b1;
            e_rd_data = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        check_val("mem_en",    mem_en,    e_en);
        check_val("mem_we",    mem_we,    e_we);
        check_val("mem_addr",  mem_addr,  e_addr);
        check_val("mem_wdata", mem_wdata, e_wdata);
        check_val("rd_valid",  rd_valid,  e_rv);
        check_val("rd_data",   rd_data,   e_rd_data);
        check_val("wr_burst",  dut.r_wr_burst, burst);
        if (mem_we === 1'b1)   we_cnt++;
        if (rd_valid === 1'b1) rv_cnt++;

        reset   = i_rst;
        wr_req  = i_wr;
        wr_addr = i_wa;
        wr_data = i_wd;
        rd_req  = i_rd;
        rd_addr = i_ra;
        #1;
        // Priority rule stated directly: writer wins unless the reader has
        // already waited through a full burst.
        g_wr = !i_rst && i_wr && (!i_rd || burst < c_MAX);
        g_rd = !i_rst && i_rd && !g_wr;
        check_val("wr_ack", wr_ack, g_wr);
        check_val("rd_ack", rd_ack, g_rd);
        check_val("acks_exclusive", wr_ack && rd_ack, 1'b0);

        if (!i_rst && i_rd && !rd_ack) rd_wait++;
        else                          rd_wait = 0;
        check_val("rd_wait_bound", rd_wait > c_MAX, 1'b0);

        if (i_rst) begin
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rd_data = 0;
            rd_q.delete();
            burst = 0;
        end else begin
            if (g_wr) begin
                e_en = 1; e_we = 1; e_addr = i_wa; e_wdata = i_wd;
                mdl_mem[i_wa] = i_wd;
            end else if (g_rd) begin
                e_en = 1; e_we = 0; e_addr = i_ra;
                rd_q.push_back('{due: cyc + 3, data: mdl_mem[i_ra]});
            end else begin
                e_en = 0; e_we = 0;
            end
            if (g_rd || !i_rd)  burst = 0;
            else if (g_wr)      burst = (burst + 1 > c_MAX) ? c_MAX : burst + 1;
        end
        last_wr_ack = wr_ack;
        last_rd_ack = rd_ack;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 17'h0, 8'h0, 1'b0, 17'h0, 1'b0);
    endtask

    logic        p_wr, p_rd, p_rst;
    logic [16:0] p_wa, p_ra;
    logic [7:0]  p_wd;

    initial begin
        for (int a = 0; a < c_DEPTH; a++) begin
            ram[a]     = a[7:0];
            mdl_mem[a] = a[7:0];
        end
        ram[17'h00100]     = 8'h5A;
        mdl_mem[17'h00100] = 8'h5A;

        cyc = 0; burst = 0; rd_wait = 0; we_cnt = 0; rv_cnt = 0;
        e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_rd_data = 0; e_rv = 0;
        last_wr_ack = 0; last_rd_ack = 0;
        reset = 1'b1; wr_req = 0; rd_req = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        step(1'b0, 17'h0, 8'h0, 1'b0, 17'h0, 1'b1);
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h0, 1'b1);

        // Single read of a preset location
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h00100, 1'b0);
        check_val("t1_rd_ack", last_rd_ack, 1'b1);
        idle(3);
        check_val("t1_rd_data", rd_data, 8'h5A);

        // Write then read of the top address
        we_cnt = 0;
        step(1'b1, 17'h1FFFF, 8'hD9, 1'b0, 17'h0, 1'b0);
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h1FFFF, 1'b0);
        idle(3);
        check_val("t2_rd_data", rd_data, 8'hD9);
        check_val("t2_we_pulses", we_cnt, 1);

        // Both requesters held high: W,W,W,W,R pattern
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 17'h00020, 8'hC3, 1'b1, 17'h00020, 1'b0);
            check_val("t3_pattern_rd", last_rd_ack, (k % 5) == 4);
        end
        idle(3);

        // Sixteen streamed reads
        rv_cnt = 0;
        for (int k = 0; k < 16; k++) step(1'b0, 17'h0, 8'h0, 1'b1, 17'(k), 1'b0);
        idle(4);
        check_val("t4_rd_strobes", rv_cnt, 16);
        check_val("t4_last_data", rd_data, 8'h0F);

        // Reset one cycle after a read handshake drops the read
        rv_cnt = 0;
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h00100, 1'b0);
        step(1'b1, 17'h3, 8'h77, 1'b1, 17'h00100, 1'b1);
        step(1'b1, 17'h3, 8'h77, 1'b1, 17'h00100, 1'b1);
        step(1'b0, 17'h0, 8'h0, 1'b0, 17'h0, 1'b0);
        idle(2);
        check_val("t5_no_valid", rv_cnt, 0);
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h00005, 1'b0);
        idle(3);
        check_val("t5_after_reset", rd_data, 8'h05);

        // Reader alone, then the writer joins
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h00040, 1'b0);
        step(1'b0, 17'h0, 8'h0, 1'b1, 17'h00041, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, 17'h00041, 8'hA5, 1'b1, 17'h00041, 1'b0);
        idle(3);

        // Randomized traffic honouring the hold-until-accepted rule
        p_wr = 0; p_rd = 0; p_wa = 0; p_ra = 0; p_wd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!(p_wr && !last_wr_ack)) begin
                p_wr = ($urandom_range(0, 99) < 55);
                p_wa = 17'($urandom_range(0, 7));
                p_wd = 8'($urandom);
            end
            if (!(p_rd && !last_rd_ack)) begin
                p_rd = ($urandom_range(0, 99) < 60);
                p_ra = 17'($urandom_range(0, 7));
            end
            p_rst = ($urandom_range(0, 99) < 2);
            step(p_wr, p_wa, p_wd, p_rd, p_ra, p_rst);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
